fifo_controller: RTL and testbench
==================================

Name: fifo_controller

Overview:
- Synchronous FIFO sequencer that drives an external dual_port_ram instance: write/read pointers, flags, fill level, RAM port control.
- The user sees a FIFO push/pop interface; the RAM sits beside the controller and holds the storage.
- The RAM read is combinational, so the FIFO is first-word-fall-through: read_data is valid whenever empty=0.

Parameters:
- WIDTH, 8, data word width; must match the RAM WIDTH.
- DEPTH, 16, number of entries; any value >=2, not restricted to powers of two.
- ADDRESS_WIDTH, `CLOG2(DEPTH), RAM address width.
- LEVEL_WIDTH, `CLOG2(DEPTH+1), width of the level output.

Ports:
- clock  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_enable  input  1  push request.
- write_data  input  WIDTH  push data.
- full  output  1  FIFO holds DEPTH entries.
- read_enable  input  1  pop request; consumes read_data this cycle.
- read_data  output  WIDTH  head-of-FIFO word; valid when empty=0.
- empty  output  1  FIFO holds 0 entries.
- level  output  LEVEL_WIDTH  current entry count, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push attempted while full.
- underflow  output  1  one-cycle pulse: pop attempted while empty.
- memory_write_enable  output  1  to RAM write_enable.
- memory_write_address  output  ADDRESS_WIDTH  to RAM write_address.
- memory_write_data  output  WIDTH  to RAM write_data.
- memory_read_enable  output  1  to RAM read_enable.
- memory_read_address  output  ADDRESS_WIDTH  to RAM read_address.
- memory_read_data  input  WIDTH  from RAM read_data.

Behaviour:
- State: write_pointer and read_pointer, each ADDRESS_WIDTH bits plus a lap bit.
- Reset (asynchronous, mid-operation included): pointers=0, laps=0, overflow=0, underflow=0.
  - Outputs after reset: empty=1, full=0, level=0.
  - Contents are discarded. The RAM is not cleared by this block; its own reset is separate.
- Pointer advance: pointer increments by 1. At DEPTH-1 it wraps to 0 and toggles its lap bit. No modulo-2^N wrap when DEPTH is not a power of two.
- Flags: combinational from registered pointers.
  - empty = (addresses equal) and (laps equal).
  - full = (addresses equal) and (laps differ).
- level:
  - laps equal: write_address - read_address.
  - laps differ: DEPTH - read_address + write_address.
  - Computed at LEVEL_WIDTH bits.
- Push accepted = write_enable and not full. Then:
  - memory_write_enable=1, memory_write_address=write pointer address, memory_write_data=write_data (all combinational).
  - Write pointer advances at the edge; the data becomes visible at read_data the cycle after.
- Pop accepted = read_enable and not empty. Then the read pointer advances at the edge.
- Read side is combinational: read_data=memory_read_data, memory_read_enable=not empty, memory_read_address=read pointer address.
- Simultaneous push+pop, neither flag set: both accepted; level unchanged.
- Push while full: rejected even if a pop occurs in the same cycle; the pop is still accepted. overflow pulses next cycle; no pointer or RAM change from the push.
- Pop while empty: rejected even with a simultaneous push; the push is still accepted. underflow pulses next cycle; read_data is don't-care.
- overflow/underflow are registered single-cycle pulses, one per offending cycle, not sticky.
- Latency:
  - Write to empty-deassert: 1 cycle.
  - Pop to next word at read_data: 1 cycle.
  - Pop from full to full deasserting: 1 cycle.

Decomposition:
- No shared package needed. Width constants come from the existing clog2.vh CLOG2 macro; no typedefs.
- One natural sub-module: wrapping_counter (parameters MAXIMUM, WIDTH; ports clock, reset, increment, count, lap). Instantiated twice, for the write and read pointers.
- The testbench instantiates fifo_controller with dual_port_ram. The RAM resetn is tied to the inverted reset.

Test Plan:
- DEPTH=4: reset, then push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> level 1,2,3,4; full=1 after the 4th edge; empty=0 from cycle 1; read_data=0xA1.
- From full, push 0xFF -> overflow=1 for one cycle, level stays 4. Then pop 4 times -> read_data 0xA1..0xA4 in order, empty=1 after the last pop.
- Wrap, DEPTH=3 (non-power-of-two): 10 push/pop pairs interleaved at level 1..2 -> data order preserved; pointer addresses cycle 0,1,2,0; level never exceeds 3.
- Simultaneous push+pop at level 2 (DEPTH=4) -> level stays 2, head advances. At level 0 with both asserted -> push taken, underflow=1, level becomes 1. At full with both asserted -> pop taken, overflow=1, level becomes 3.
- Pop while empty after reset -> underflow pulses exactly one cycle; pointers unchanged; memory_read_enable=0.
- Assert reset asynchronously mid-burst at level 3 -> empty=1, level=0, full=0 immediately without a clock edge. The next push of 0x5C appears at read_data one cycle later.

Source files
------------

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write port, combinational read port.
// Its own active-low reset clears the array; the FIFO controller never clears it.
module dual_port_ram #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] memory_r [DEPTH];

  // Storage update
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory_r[i] <= '0;
      end
    end else if (write_enable) begin
      memory_r[write_address] <= write_data;
    end
  end

  assign read_data = read_enable ? memory_r[read_address] : '0;

endmodule

// File: rtl/wrapping_counter.sv
// Pointer counter that runs 0..MAXIMUM and toggles a lap bit each time it wraps to zero.
// The lap bit lets equal addresses be told apart as empty or full for any depth.
module wrapping_counter #(
  parameter int MAXIMUM = 15,
  parameter int WIDTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count,
  output logic             lap
);

  // Advance on increment, wrapping explicitly at MAXIMUM rather than at 2^WIDTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      lap   <= 1'b0;
    end else if (increment) begin
      if (count == WIDTH'(MAXIMUM)) begin
        count <= '0;
        lap   <= ~lap;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_controller.sv
// First-word-fall-through FIFO sequencer driving an external dual-port RAM.
// Flags and level derive combinationally from the registered pointers; error pulses are registered.
module fifo_controller #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LEVEL_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [WIDTH-1:0]         write_data,
  output logic                     full,
  input  logic                     read_enable,
  output logic [WIDTH-1:0]         read_data,
  output logic                     empty,
  output logic [LEVEL_WIDTH-1:0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_write_address,
  output logic [WIDTH-1:0]         memory_write_data,
  output logic                     memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_read_address,
  input  logic [WIDTH-1:0]         memory_read_data
);

  logic [ADDRESS_WIDTH-1:0] write_address_s;
  logic [ADDRESS_WIDTH-1:0] read_address_s;
  logic                     write_lap_s;
  logic                     read_lap_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     empty_s;
  logic                     full_s;
  logic [LEVEL_WIDTH-1:0]   level_s;
  logic                     overflow_r;
  logic                     underflow_r;

  wrapping_counter #(.MAXIMUM(DEPTH - 1), .WIDTH(ADDRESS_WIDTH)) u_write_pointer (
    .clock     (clock),
    .reset     (reset),
    .increment (push_s),
    .count     (write_address_s),
    .lap       (write_lap_s)
  );

  wrapping_counter #(.MAXIMUM(DEPTH - 1), .WIDTH(ADDRESS_WIDTH)) u_read_pointer (
    .clock     (clock),
    .reset     (reset),
    .increment (pop_s),
    .count     (read_address_s),
    .lap       (read_lap_s)
  );

  assign empty_s = (write_address_s == read_address_s) && (write_lap_s == read_lap_s);
  assign full_s  = (write_address_s == read_address_s) && (write_lap_s != read_lap_s);
  // A rejected request never blocks the other side in the same cycle
  assign push_s  = write_enable && !full_s;
  assign pop_s   = read_enable && !empty_s;

  // Occupancy; when laps differ the writer is one lap ahead of the reader
  always_comb begin
    if (write_lap_s == read_lap_s) begin
      level_s = LEVEL_WIDTH'(write_address_s) - LEVEL_WIDTH'(read_address_s);
    end else begin
      level_s = LEVEL_WIDTH'(DEPTH) - LEVEL_WIDTH'(read_address_s) + LEVEL_WIDTH'(write_address_s);
    end
  end

  // One pulse per offending cycle, never sticky
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= write_enable && full_s;
      underflow_r <= read_enable && empty_s;
    end
  end

  assign full                 = full_s;
  assign empty                = empty_s;
  assign level                = level_s;
  assign overflow             = overflow_r;
  assign underflow            = underflow_r;
  assign memory_write_enable  = push_s;
  assign memory_write_address = write_address_s;
  assign memory_write_data    = write_data;
  assign memory_read_enable   = !empty_s;
  assign memory_read_address  = read_address_s;
  assign read_data            = memory_read_data;

endmodule

// File: tb/tb_fifo_controller.sv
// Scoreboard bench: a DEPTH=4 and a DEPTH=3 FIFO, each beside its own RAM.
module tb_fifo_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // DEPTH=4 instance
  logic       a_we = 1'b0, a_re = 1'b0;
  logic [7:0] a_wd = 8'h00;
  logic       a_full, a_empty, a_ovf, a_unf, a_mwe, a_mre;
  logic [7:0] a_rd, a_mwd, a_mrd;
  logic [2:0] a_level;
  logic [1:0] a_mwa, a_mra;

  // DEPTH=3 instance
  logic       b_we = 1'b0, b_re = 1'b0;
  logic [7:0] b_wd = 8'h00;
  logic       b_full, b_empty, b_ovf, b_unf, b_mwe, b_mre;
  logic [7:0] b_rd, b_mwd, b_mrd;
  logic [1:0] b_level;
  logic [1:0] b_mwa, b_mra;

  logic [7:0] exp_q4[$];
  logic [7:0] exp_q3[$];
  logic       mwe_cap;
  logic [1:0] mwa_cap;

  fifo_controller #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .write_enable(a_we), .write_data(a_wd), .full(a_full),
    .read_enable(a_re), .read_data(a_rd), .empty(a_empty), .level(a_level),
    .overflow(a_ovf), .underflow(a_unf), .memory_write_enable(a_mwe),
    .memory_write_address(a_mwa), .memory_write_data(a_mwd), .memory_read_enable(a_mre),
    .memory_read_address(a_mra), .memory_read_data(a_mrd)
  );
  dual_port_ram #(.WIDTH(8), .DEPTH(4)) ram4 (
    .clock(clock), .resetn(~reset), .write_enable(a_mwe), .write_address(a_mwa),
    .write_data(a_mwd), .read_enable(a_mre), .read_address(a_mra), .read_data(a_mrd)
  );

  fifo_controller #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clock(clock), .reset(reset), .write_enable(b_we), .write_data(b_wd), .full(b_full),
    .read_enable(b_re), .read_data(b_rd), .empty(b_empty), .level(b_level),
    .overflow(b_ovf), .underflow(b_unf), .memory_write_enable(b_mwe),
    .memory_write_address(b_mwa), .memory_write_data(b_mwd), .memory_read_enable(b_mre),
    .memory_read_address(b_mra), .memory_read_data(b_mrd)
  );
  dual_port_ram #(.WIDTH(8), .DEPTH(3)) ram3 (
    .clock(clock), .resetn(~reset), .write_enable(b_mwe), .write_address(b_mwa),
    .write_data(b_mwd), .read_enable(b_mre), .read_address(b_mra), .read_data(b_mrd)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of DEPTH=4 stimulus; accepted pushes go to the scoreboard
  task automatic step4(input logic we, input logic [7:0] wd, input logic re, input logic accept);
    a_we = we; a_wd = wd; a_re = re;
    if (accept) exp_q4.push_back(wd);
    #2;
    mwe_cap = a_mwe; mwa_cap = a_mwa;
    @(posedge clock); #1;
    a_we = 1'b0; a_re = 1'b0;
  endtask

  task automatic step3(input logic we, input logic [7:0] wd, input logic re, input logic accept);
    b_we = we; b_wd = wd; b_re = re;
    if (accept) exp_q3.push_back(wd);
    #2;
    mwe_cap = b_mwe; mwa_cap = b_mwa;
    @(posedge clock); #1;
    b_we = 1'b0; b_re = 1'b0;
  endtask

  // Monitors: every accepted pop must present the oldest expected word
  always @(negedge clock) begin : mon4
    logic [7:0] w;
    if (!reset && a_re && !a_empty) begin
      if (exp_q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard4: unexpected pop, got %0h expected nothing", a_rd);
      end else begin
        w = exp_q4.pop_front();
        check("scoreboard4", {24'h0, a_rd}, {24'h0, w});
      end
    end
  end

  always @(negedge clock) begin : mon3
    logic [7:0] w;
    if (!reset && b_re && !b_empty) begin
      if (exp_q3.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard3: unexpected pop, got %0h expected nothing", b_rd);
      end else begin
        w = exp_q3.pop_front();
        check("scoreboard3", {24'h0, b_rd}, {24'h0, w});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_empty", a_empty, 1);
    check("reset_full", a_full, 0);
    check("reset_level", a_level, 0);
    check("reset_ovf_unf", {a_ovf, a_unf}, 0);

    // Pop while empty: one underflow pulse, nothing moves
    step4(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_pulse", a_unf, 1);
    check("unf_level", a_level, 0);
    check("unf_mre", a_mre, 0);
    check("unf_rptr", a_mra, 0);
    step4(1'b0, 8'h00, 1'b0, 1'b0);
    check("unf_cleared", a_unf, 0);

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      step4(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b1);
      check("fill_mwe", mwe_cap, 1);
      check("fill_mwa", mwa_cap, i);
      check("fill_level", a_level, i + 1);
      check("fill_empty", a_empty, 0);
      check("fill_head", a_rd, 8'hA1);
      check("fill_full", a_full, (i == 3) ? 1 : 0);
    end

    // Push while full
    step4(1'b1, 8'hFF, 1'b0, 1'b0);
    check("ovf_mwe", mwe_cap, 0);
    check("ovf_pulse", a_ovf, 1);
    check("ovf_level", a_level, 4);
    step4(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_cleared", a_ovf, 0);

    // Drain
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_level", a_level, 3 - i);
      check("drain_full", a_full, 0);
      check("drain_empty", a_empty, (i == 3) ? 1 : 0);
    end

    // Both at level 0: push taken, pop rejected
    step4(1'b1, 8'h11, 1'b1, 1'b1);
    check("both0_unf", a_unf, 1);
    check("both0_level", a_level, 1);
    step4(1'b1, 8'h12, 1'b0, 1'b1);
    // Both at level 2: level steady, head advances
    step4(1'b1, 8'h13, 1'b1, 1'b1);
    check("both2_level", a_level, 2);
    check("both2_head", a_rd, 8'h12);
    step4(1'b1, 8'h14, 1'b0, 1'b1);
    step4(1'b1, 8'h15, 1'b0, 1'b1);
    check("refill_full", a_full, 1);
    // Both at full: pop taken, push rejected
    step4(1'b1, 8'h16, 1'b1, 1'b0);
    check("bothF_ovf", a_ovf, 1);
    check("bothF_level", a_level, 3);
    check("bothF_head", a_rd, 8'h13);

    // Asynchronous reset mid-burst at level 3
    a_we = 1'b1; a_wd = 8'h17;
    #2 reset = 1'b1;
    #1;
    check("areset_empty", a_empty, 1);
    check("areset_level", a_level, 0);
    check("areset_full", a_full, 0);
    exp_q4.delete();
    a_we = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    step4(1'b1, 8'h5C, 1'b0, 1'b1);
    check("post_reset_data", a_rd, 8'h5C);
    check("post_reset_level", a_level, 1);
    step4(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_empty", a_empty, 1);

    // DEPTH=3 wrap: addresses cycle 0,1,2,0,...
    step3(1'b1, 8'h30, 1'b0, 1'b1);
    check("w3_first_mwa", mwa_cap, 0);
    for (int i = 0; i < 10; i++) begin
      step3(1'b1, 8'h31 + 8'(i), 1'b0, 1'b1);
      check("w3_mwa", mwa_cap, (i + 1) % 3);
      check("w3_level_push", b_level, 2);
      step3(1'b0, 8'h00, 1'b1, 1'b0);
      check("w3_level_pop", b_level, 1);
      check("w3_mra", b_mra, (i + 1) % 3);
    end
    step3(1'b0, 8'h00, 1'b1, 1'b0);
    check("w3_empty", b_empty, 1);
    check("w3_full", b_full, 0);

    repeat (2) @(posedge clock);
    check("q4_drained", exp_q4.size(), 0);
    check("q3_drained", exp_q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
